// File: rtl/spectrum_to_vga_if.sv
// -----------------------------------------------------------------------------
// spectrum_to_vga_if
//
// This interface groups the FFT source stream and the VGA register write port
// used by spectrum_to_vga.
//
// Parameter:
//   BANDS  number of display bands. It sets the width of vga_addr.
//
// Signals:
//   src_valid / src_sop / src_eop           FFT Avalon-ST framing.
//   src_real / src_imag                     signed 16-bit bin value.
//   src_exp                                 signed block exponent, valid with sop.
//   src_ready                               back-pressure to the FFT source.
//   vga_ready                               display accepts the current write.
//   vga_dat / vga_addr / vga_dowrite        band write request.
//   exp_out                                 exponent of the last completed frame.
//   frame_done / frame_err                  one-cycle status pulses.
//
// Modports:
//   master  the environment side (FFT source and display).
//   slave   the spectrum_to_vga side.
// -----------------------------------------------------------------------------
interface spectrum_to_vga_if #(
    parameter int BANDS = 32
);
    localparam int ADDR_W = $clog2(BANDS);

    logic               src_valid;
    logic               src_sop;
    logic               src_eop;
    logic signed [15:0] src_real;
    logic signed [15:0] src_imag;
    logic [5:0]         src_exp;
    logic               src_ready;

    logic               vga_ready;
    logic [15:0]        vga_dat;
    logic [ADDR_W-1:0]  vga_addr;
    logic               vga_dowrite;

    logic [5:0]         exp_out;
    logic               frame_done;
    logic               frame_err;

    modport master (
        output src_valid, src_sop, src_eop, src_real, src_imag, src_exp,
        input  src_ready,
        output vga_ready,
        input  vga_dat, vga_addr, vga_dowrite, exp_out, frame_done, frame_err
    );

    modport slave (
        input  src_valid, src_sop, src_eop, src_real, src_imag, src_exp,
        output src_ready,
        input  vga_ready,
        output vga_dat, vga_addr, vga_dowrite, exp_out, frame_done, frame_err
    );
endinterface

// File: rtl/spectrum_to_vga.sv
// -----------------------------------------------------------------------------
// spectrum_to_vga
//
// This module reduces each forward-FFT output frame to BANDS magnitude values
// and writes them to the VGA spectrum display, one band per accepted write.
// For each band it sums |re|+|im| over that band's contiguous group of
// positive-frequency bins. The sum is right-shifted by OUT_SHIFT and then
// saturated to 16 bits.
//
// Ports:
//   fft_clk  sole clock. All logic runs on its rising edge.
//   reset    asynchronous, active-high reset.
//   bus      spectrum_to_vga_if.slave. It carries the FFT stream in and the
//            VGA write port and status pulses out.
//
// Parameters:
//   FFT_POINTS  bins per frame. Must be a power of two.
//   BANDS       output bands. Must be a power of two and divide FFT_POINTS/2.
//   OUT_SHIFT   right shift applied to a band sum before saturation.
//
// Optional feature (macro SPECTRUM_PEAK_HOLD_EN):
//   Each band keeps a 16-bit held value. At drain entry the held value
//   becomes max(new, held - held/16), and vga_dat shows the held value.
// -----------------------------------------------------------------------------
module spectrum_to_vga #(
    parameter int FFT_POINTS = 4096,
    parameter int BANDS      = 32,
    parameter int OUT_SHIFT  = 6
) (
    input  logic               fft_clk,
    input  logic               reset,
    spectrum_to_vga_if.slave   bus
);
    localparam int BIN_W  = $clog2(FFT_POINTS);
    localparam int BPB    = FFT_POINTS / 2 / BANDS;     // bins per band
    localparam int BPB_W  = $clog2(BPB);
    localparam int BAND_W = $clog2(BANDS);
    localparam int ACC_W  = 17 + BPB_W;

    localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'(FFT_POINTS - 1);
    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(BANDS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

    state_t            state;
    logic [BIN_W-1:0]  bin_cnt;     // index of the next expected bin
    logic              flush_cnt;
    logic [5:0]        exp_lat;

    // Magnitude stage, one register deep.
    logic [16:0]       mag_q;
    logic              mag_vld;
    logic [BAND_W-1:0] mag_band;

    logic [ACC_W-1:0]  acc [BANDS];

    // ---------------------------------------------------------------- input
    logic              beat;
    logic              start;
    logic              in_frame;
    logic [BIN_W-1:0]  cur_bin;
    logic [16:0]       re_x, im_x, re_abs, im_abs, mag;

    // NOTE: each signal written in always_comb gets a value on every path.
    // Otherwise synthesis infers a latch.
    always_comb begin
        beat     = bus.src_valid & bus.src_ready;
        start    = beat & bus.src_sop & ((state == IDLE) | (state == ACCUM));
        in_frame = start | (beat & (state == ACCUM));
        cur_bin  = start ? '0 : bin_cnt;

        // Sign-extend to 17 bits before negating, so |-32768| = 32768 fits.
        re_x   = {bus.src_real[15], bus.src_real};
        im_x   = {bus.src_imag[15], bus.src_imag};
        re_abs = re_x[16] ? (~re_x + 17'd1) : re_x;
        im_abs = im_x[16] ? (~im_x + 17'd1) : im_x;
        mag    = re_abs + im_abs;
    end

    function automatic logic [15:0] sat16(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] s;
        s = a >> OUT_SHIFT;
        return (s > ACC_W'(16'hFFFF)) ? 16'hFFFF : s[15:0];
    endfunction

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge fft_clk or posedge reset) begin
        if (reset) begin
            mag_q    <= '0;
            mag_vld  <= 1'b0;
            mag_band <= '0;
        end else begin
            // Only the lower (positive-frequency) half feeds the bands.
            mag_q    <= mag;
            mag_vld  <= in_frame & ~cur_bin[BIN_W-1];
            mag_band <= cur_bin[BPB_W +: BAND_W];
        end
    end

    // NOTE: the accumulators are a register array, not a RAM. A reset must
    // clear them, so they take the async reset like any other register.
    always_ff @(posedge fft_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BANDS; i++) acc[i] <= '0;
        end else if (start) begin
            // Clearing wins over a stale add that is still in the pipe.
            for (int i = 0; i < BANDS; i++) acc[i] <= '0;
        end else if (mag_vld) begin
            acc[mag_band] <= acc[mag_band] + ACC_W'(mag_q);
        end
    end

    // ------------------------------------------------------- output values
    logic              drain_entry;
    logic [BAND_W-1:0] next_idx;
    logic [15:0]       entry_dat;
    logic [15:0]       next_dat;

`ifdef SPECTRUM_PEAK_HOLD_EN
    logic [15:0] held      [BANDS];
    logic [15:0] held_next [BANDS];

    always_comb begin
        for (int i = 0; i < BANDS; i++) begin
            held_next[i] = (sat16(acc[i]) > (held[i] - (held[i] >> 4)))
                         ? sat16(acc[i]) : (held[i] - (held[i] >> 4));
        end
    end

    // Held values ignore frame errors and change only at drain entry.
    always_ff @(posedge fft_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BANDS; i++) held[i] <= '0;
        end else if (drain_entry) begin
            for (int i = 0; i < BANDS; i++) held[i] <= held_next[i];
        end
    end
`endif

    always_comb begin
        drain_entry = (state == FLUSH) & flush_cnt;
        next_idx    = bus.vga_addr + BAND_W'(1);
`ifdef SPECTRUM_PEAK_HOLD_EN
        entry_dat   = held_next[0];
        next_dat    = held[next_idx];
`else
        entry_dat   = sat16(acc[0]);
        next_dat    = sat16(acc[next_idx]);
`endif
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge fft_clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            bin_cnt         <= '0;
            flush_cnt       <= 1'b0;
            exp_lat         <= '0;
            bus.src_ready   <= 1'b0;
            bus.vga_dowrite <= 1'b0;
            bus.vga_dat     <= '0;
            bus.vga_addr    <= '0;
            bus.exp_out     <= '0;
            bus.frame_done  <= 1'b0;
            bus.frame_err   <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;

            case (state)
                IDLE, ACCUM: begin
                    bus.src_ready <= 1'b1;
                    if (in_frame) begin
                        if (start) exp_lat <= bus.src_exp;
                        // A sop inside a frame restarts it.
                        if (start && state == ACCUM) bus.frame_err <= 1'b1;

                        if (cur_bin == LAST_BIN) begin
                            if (bus.src_eop) begin
                                state         <= FLUSH;
                                flush_cnt     <= 1'b0;
                                bus.src_ready <= 1'b0;
                            end else begin
                                state         <= IDLE;
                                bus.frame_err <= 1'b1;
                            end
                        end else if (bus.src_eop) begin
                            state         <= IDLE;
                            bus.frame_err <= 1'b1;
                        end else begin
                            state   <= ACCUM;
                            bin_cnt <= cur_bin + BIN_W'(1);
                        end
                    end
                end

                // Two dead cycles let the final beat reach its accumulator.
                FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        state           <= DRAIN;
                        bus.exp_out     <= exp_lat;
                        bus.vga_dowrite <= 1'b1;
                        bus.vga_addr    <= '0;
                        bus.vga_dat     <= entry_dat;
                    end
                end

                DRAIN: begin
                    if (bus.vga_ready) begin
                        if (bus.vga_addr == LAST_BAND) begin
                            state           <= IDLE;
                            bus.vga_dowrite <= 1'b0;
                            bus.frame_done  <= 1'b1;
                            bus.src_ready   <= 1'b1;
                        end else begin
                            bus.vga_addr <= next_idx;
                            bus.vga_dat  <= next_dat;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spectrum_to_vga.sv
// -----------------------------------------------------------------------------
// tb_spectrum_to_vga
//
// This is a self-checking bench for spectrum_to_vga at its default parameters.
// A reference model computes the band values for each good frame and pushes
// them to a scoreboard queue. A monitor pops one entry per accepted VGA write
// and compares it with the write. Directed steps cover reset, latency,
// back-pressure, frame errors and reset during drain.
// -----------------------------------------------------------------------------
module tb_spectrum_to_vga;
    localparam int FFT_POINTS = 4096;
    localparam int BANDS      = 32;
    localparam int OUT_SHIFT  = 6;
    localparam int HALF       = FFT_POINTS / 2;
    localparam int BPB        = HALF / BANDS;

    logic clk = 1'b0;
    logic reset;

    spectrum_to_vga_if #(.BANDS(BANDS)) bus();

    spectrum_to_vga #(
        .FFT_POINTS (FFT_POINTS),
        .BANDS      (BANDS),
        .OUT_SHIFT  (OUT_SHIFT)
    ) dut (
        .fft_clk (clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] dat;
    } wr_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;
    int  model_held [BANDS];
    int  bp_mode  = 0;
    int  err_at_sop, err_at_end, ready_drops;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Bin contents for each stimulus kind.
    task automatic bin_val(input int kind, input int b, output int re, output int im);
        re = 0;
        im = 0;
        case (kind)
            0: if (b == 0) re = 1000;
            1: if (b >= 64 && b <= 127) begin re = -32768; im = -32768; end
            2: begin
                if (b < HALF) begin
                    re = ((b * 37) % 2001) - 1000;
                    im = (b % 3 == 0) ? -(b % 500) : (b % 700);
                end else begin
                    re = -32768;
                    im = 32767;
                end
            end
            3: if (b == 0) re = 160 << OUT_SHIFT;
            default: ;
        endcase
    endtask

    task automatic push_expected(input int kind);
        longint acc [BANDS];
        longint s;
        int re, im;
        for (int i = 0; i < BANDS; i++) acc[i] = 0;
        for (int b = 0; b < HALF; b++) begin
            bin_val(kind, b, re, im);
            acc[b / BPB] += (re < 0 ? -re : re) + (im < 0 ? -im : im);
        end
        for (int i = 0; i < BANDS; i++) begin
            s = acc[i] >> OUT_SHIFT;
            if (s > 65535) s = 65535;
`ifdef SPECTRUM_PEAK_HOLD_EN
            begin
                int d;
                d = model_held[i] - (model_held[i] >> 4);
                model_held[i] = (int'(s) > d) ? int'(s) : d;
                s = model_held[i];
            end
`endif
            sb.push_back('{addr: 5'(i), dat: 16'(s)});
        end
    endtask

    // Drives one frame, one beat per cycle. The caller sits at posedge+1.
    task automatic send_frame(input int kind, input int len, input bit with_eop, input logic [5:0] fexp);
        int re, im, n;
        n = 0;
        while (!bus.src_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("src_ready_before_frame", bus.src_ready, 1);
        ready_drops = 0;
        err_at_sop  = 0;
        for (int b = 0; b < len; b++) begin
            bin_val(kind, b, re, im);
            bus.src_valid = 1'b1;
            bus.src_sop   = (b == 0);
            bus.src_eop   = with_eop && (b == len - 1);
            bus.src_real  = 16'(re);
            bus.src_imag  = 16'(im);
            bus.src_exp   = (b == 0) ? fexp : 6'h2A;
            if (!bus.src_ready) ready_drops++;
            @(posedge clk); #1;
            if (b == 0) err_at_sop = bus.frame_err;
        end
        err_at_end    = bus.frame_err;
        bus.src_valid = 1'b0;
        bus.src_sop   = 1'b0;
        bus.src_eop   = 1'b0;
    endtask

    // Called at posedge+1 right after the eop beat has transferred.
    task automatic finish_frame(input logic [5:0] fexp);
        int n, pulses, err_seen;
        check("frame_ready_drops", ready_drops, 0);
        check("flush_src_ready", bus.src_ready, 0);
        @(posedge clk); #1;
        check("flush_dowrite", bus.vga_dowrite, 0);
        check("flush_src_ready2", bus.src_ready, 0);
        @(posedge clk); #1;
        check("first_write_latency", bus.vga_dowrite, 1);
        check("exp_out", bus.exp_out, fexp);
        n = 0;
        pulses = 0;
        err_seen = 0;
        while (n < 400 && pulses == 0) begin
            @(posedge clk); #1;
            n++;
            if (bus.frame_done) begin
                pulses++;
                err_seen = bus.frame_err;
            end
        end
        check("frame_done_seen", pulses, 1);
        check("done_err_exclusive", err_seen, 0);
        check("src_ready_at_done", bus.src_ready, 1);
        check("sb_drained", sb.size(), 0);
        @(posedge clk); #1;
        check("frame_done_width", bus.frame_done, 0);
    endtask

    // Ready pattern for the display side: 1-0-0-1 under back-pressure.
    initial begin
        int ph;
        ph = 0;
        bus.vga_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_mode != 0) begin
                bus.vga_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                ph++;
            end else begin
                bus.vga_ready = 1'b1;
                ph = 0;
            end
        end
    end

    // Scoreboard monitor. It samples on the falling edge.
    initial begin
        logic        prev_stall;
        logic [4:0]  prev_addr;
        logic [15:0] prev_dat;
        wr_t         e;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_dat   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && bus.vga_dowrite) begin
                    check("stall_addr", bus.vga_addr, prev_addr);
                    check("stall_dat", bus.vga_dat, prev_dat);
                end
                if (bus.vga_dowrite) begin
                    check("src_ready_in_drain", bus.src_ready, 0);
                    if (bus.vga_ready) begin
                        check("sb_nonempty", sb.size() > 0, 1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            check("band_addr", bus.vga_addr, e.addr);
                            check("band_dat", bus.vga_dat, e.dat);
                        end
                    end
                end
                prev_stall = bus.vga_dowrite && !bus.vga_ready;
                prev_addr  = bus.vga_addr;
                prev_dat   = bus.vga_dat;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen;
        reset         = 1'b1;
        bus.src_valid = 1'b0;
        bus.src_sop   = 1'b0;
        bus.src_eop   = 1'b0;
        bus.src_real  = '0;
        bus.src_imag  = '0;
        bus.src_exp   = '0;
        for (int i = 0; i < BANDS; i++) model_held[i] = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_src_ready", bus.src_ready, 0);
        check("rst_dowrite", bus.vga_dowrite, 0);
        check("rst_dat", bus.vga_dat, 0);
        check("rst_addr", bus.vga_addr, 0);
        check("rst_exp_out", bus.exp_out, 0);
        check("rst_done", bus.frame_done, 0);
        check("rst_err", bus.frame_err, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_src_ready", bus.src_ready, 1);

        // Beats without sop in IDLE are discarded.
        for (int i = 0; i < 5; i++) begin
            bus.src_valid = 1'b1;
            bus.src_real  = 16'sd12345;
            bus.src_imag  = -16'sd321;
            @(posedge clk); #1;
        end
        bus.src_valid = 1'b0;
        check("idle_junk_no_err", bus.frame_err, 0);

        // DC frame
        push_expected(0);
        send_frame(0, FFT_POINTS, 1'b1, 6'd3);
        check("dc_err_sop", err_at_sop, 0);
        check("dc_err_end", err_at_end, 0);
        finish_frame(6'd3);

        // Full-scale tone in band 1 saturates
        push_expected(1);
        send_frame(1, FFT_POINTS, 1'b1, 6'h3F);
        check("fs_err_end", err_at_end, 0);
        finish_frame(6'h3F);

        // Back-pressure during drain
        bp_mode = 1;
        push_expected(2);
        send_frame(2, FFT_POINTS, 1'b1, 6'd20);
        finish_frame(6'd20);
        bp_mode = 0;

        // sop inside a frame restarts it
        send_frame(2, 50, 1'b0, 6'd7);
        check("partial_no_err", err_at_end, 0);
        push_expected(0);
        send_frame(0, FFT_POINTS, 1'b1, 6'd9);
        check("restart_err_pulse", err_at_sop, 1);
        check("restart_err_end", err_at_end, 0);
        finish_frame(6'd9);

        // Short frame: eop at bin 100
        send_frame(2, 101, 1'b1, 6'd11);
        check("short_err", err_at_end, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.vga_dowrite) seen++;
        end
        check("short_no_write", seen, 0);
        check("short_src_ready", bus.src_ready, 1);

        // Count reaches FFT_POINTS without eop
        send_frame(5, FFT_POINTS, 1'b0, 6'd12);
        check("long_err", err_at_end, 1);

        // Good frame after errors drains normally
        push_expected(1);
        send_frame(1, FFT_POINTS, 1'b1, 6'd13);
        finish_frame(6'd13);

        // Reset while band 10 is presented
        push_expected(2);
        send_frame(2, FFT_POINTS, 1'b1, 6'd14);
        n = 0;
        seen = 0;
        while (n < 200 && seen == 0) begin
            @(posedge clk); #1;
            n++;
            if (bus.vga_dowrite && bus.vga_addr == 5'd10) seen = 1;
        end
        check("reached_band10", seen, 1);
        reset = 1'b1;
        #1;
        check("midrst_dowrite", bus.vga_dowrite, 0);
        check("midrst_dat", bus.vga_dat, 0);
        check("midrst_addr", bus.vga_addr, 0);
        check("midrst_exp_out", bus.exp_out, 0);
        check("midrst_src_ready", bus.src_ready, 0);
        check("midrst_done", bus.frame_done, 0);
        sb.delete();
        for (int i = 0; i < BANDS; i++) model_held[i] = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Next frame starts at band 0
        push_expected(0);
        send_frame(0, FFT_POINTS, 1'b1, 6'd15);
        finish_frame(6'd15);

`ifdef SPECTRUM_PEAK_HOLD_EN
        // Band 0 raw 160, then 0: the held value decays by 1/16
        push_expected(3);
        send_frame(3, FFT_POINTS, 1'b1, 6'd16);
        finish_frame(6'd16);
        push_expected(5);
        send_frame(5, FFT_POINTS, 1'b1, 6'd17);
        finish_frame(6'd17);
`endif

        check("sb_empty_end", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spectrum_to_vga.md
# spectrum_to_vga

Consumes the forward-FFT output stream of the audio path (Avalon-ST real/imag/sop/eop/valid plus block exponent) and reduces each frame to `BANDS` magnitude values for the VGA spectrum display. It sits directly downstream of the forward FFT on `fft_clk` and drives the VGA register write port (`vga_dat`/`vga_addr`/`vga_dowrite`). Each band value is the sum of |re|+|im| over a contiguous group of positive-frequency bins, shifted and saturated to 16 bits. Bands are written out one per accepted handshake after the frame ends.

## Interface
- `FFT_POINTS`, 4096: bins per frame; power of two.
- `BANDS`, 32: output bands; power of two, divides `FFT_POINTS/2`.
- `OUT_SHIFT`, 6: right shift applied to the band accumulator before saturation.

- `fft_clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `src_valid`  in  1  FFT source valid.
- `src_sop`  in  1  first bin of frame.
- `src_eop`  in  1  last bin of frame.
- `src_real`  in  16  signed bin real part.
- `src_imag`  in  16  signed bin imaginary part.
- `src_exp`  in  6  signed block exponent; sampled with sop.
- `src_ready`  out  1  to FFT `source_ready`; a beat transfers when valid&ready.
- `vga_ready`  in  1  display side accepts the current write.
- `vga_dat`  out  16  band magnitude.
- `vga_addr`  out  log2(BANDS)  band index.
- `vga_dowrite`  out  1  write request; held until accepted.
- `exp_out`  out  6  exponent of the last completed frame.
- `frame_done`  out  1  one-cycle pulse after the last band is accepted.
- `frame_err`  out  1  one-cycle pulse on a malformed frame.

## Operation
- States: IDLE, ACCUM, FLUSH, DRAIN.
- IDLE: `src_ready`=1. Beats without sop are discarded. A beat with sop latches `src_exp`, clears all band accumulators, sets the bin counter to 0, processes that beat as bin 0, and enters ACCUM.
- ACCUM: `src_ready`=1.
  - Each beat computes mag = |re|+|im| in 17 bits unsigned; |−32768| = 32768.
  - Bin b < `FFT_POINTS/2` adds into band b / (`FFT_POINTS/2/BANDS`), with accumulator width 17+log2(bins per band) = 23 bits at defaults.
  - Bins ≥ `FFT_POINTS/2` are counted but not accumulated.
- sop inside ACCUM restarts the frame as in IDLE, and `frame_err` pulses.
- eop with bin count = `FFT_POINTS`−1 goes to FLUSH. eop at any other count, or a count reaching `FFT_POINTS` without eop, pulses `frame_err`, discards the frame and returns to IDLE.
- FLUSH: `src_ready`=0 for exactly 2 cycles to drain the add pipeline; then `exp_out` takes the latched exponent and the state becomes DRAIN at band 0.
- DRAIN: `src_ready`=0.
  - `vga_dat` = min(acc >> `OUT_SHIFT`, 16'hFFFF), with `vga_addr` = band index and `vga_dowrite`=1.
  - On a cycle where `vga_ready`=1, the band index advances and the next band is presented on the next cycle. `vga_dowrite` stays high back-to-back.
  - After band `BANDS`−1 is accepted: `vga_dowrite`=0, `frame_done` pulses, and the state returns to IDLE.
- Reset values: state IDLE, `src_ready`=0 during reset then 1, `vga_dowrite`=0, `vga_dat`=0, `vga_addr`=0, `exp_out`=0, `frame_done`=0, `frame_err`=0, all accumulators 0. Asserting reset mid-frame or mid-drain abandons the frame immediately.

## Timing
- The magnitude stage is registered (1 cycle) and accumulation is 1 cycle, so a beat's contribution is in its band register 2 cycles after transfer.
- The first `vga_dowrite` occurs 3 cycles after the eop beat transfer.
- Minimum drain: `BANDS` cycles with `vga_ready` held high.
- `vga_dat` and `vga_addr` are stable while `vga_dowrite`=1 and `vga_ready`=0.
- Back-to-back frames: the next sop is accepted the cycle after `frame_done`.
- `frame_err` and `frame_done` never assert in the same cycle.

## Configuration
- `SPECTRUM_PEAK_HOLD_EN` defined: each band keeps a 16-bit held value.
  - At DRAIN entry, held = max(new, held − (held >> 4)); `vga_dat` outputs held.
  - Held values reset to 0 and survive `frame_err`.
- Undefined: `vga_dat` is the raw saturated band value and no held registers exist.

## Test plan
- DC frame: bin 0 = (1000, 0), all other bins 0, defaults → band 0 `vga_dat`=15 (1000>>6), bands 1–31 = 0, `frame_done` once.
- Full-scale tone: bins 64–127 each (−32768, −32768) → band 1 acc = 64·65536, >>6 = 65536, saturates to 16'hFFFF; other bands 0.
- Backpressure: `vga_ready` toggling 1-0-0-1 throughout drain → each `vga_addr` 0..31 presented once with stable data; `src_ready`=0 until `frame_done`.
- Short frame: eop at bin 100 → `frame_err` pulse, no `vga_dowrite`, next good frame drains normally.
- Reset at band 10 of drain → outputs return to reset values the same cycle; the next frame starts at band 0.
- With `SPECTRUM_PEAK_HOLD_EN`: band 0 raw values 160 then 0 → outputs 160, then 150.
